// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder: FSM state codes, legal request size, latency bounds.
package mem_responder_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_RD_WAIT = 3'd1;
  localparam logic [STATE_W-1:0] ST_RD_RESP = 3'd2;
  localparam logic [STATE_W-1:0] ST_WR_WAIT = 3'd3;
  localparam logic [STATE_W-1:0] ST_WR_RESP = 3'd4;

  // Only single 32-bit word accesses are accepted.
  localparam int unsigned SIZE_BYTES = 4;

  // Latency counter range; a 4-bit counter covers the full range.
  localparam int unsigned LAT_MIN = 1;
  localparam int unsigned LAT_MAX = 15;
  localparam int unsigned CNT_W   = 4;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM with a registered read port.
// The read register is reset to zero and only changes on a read, so it doubles
// as the responder's held read_data; a read with rd_zero_i set returns zero.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WID = 14,
  parameter int unsigned DATA_WID = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                we_i,
  input  logic                rd_zero_i,
  input  logic [ADDR_WID-1:0] addr_i,
  input  logic [DATA_WID-1:0] wdata_i,
  output logic [DATA_WID-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WID;

  logic [DATA_WID-1:0] mem_q [DEPTH];
  logic [DATA_WID-1:0] rdata_q;

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read, held between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= rd_zero_i ? '0 : mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts single-word read/write strobes, services them
// from an internal RAM after LATENCY cycles and answers with a one-cycle ready.
// One request is in flight at a time; one more can wait in the pending slot.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WID = 14,
  parameter int unsigned DATA_WID = 32,
  parameter int unsigned LATENCY  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic                read_enable,
  input  logic [63:0]         read_addr,
  input  logic [63:0]         read_size,
  input  logic                write_enable,
  input  logic [63:0]         write_addr,
  input  logic [63:0]         write_size,
  input  logic [DATA_WID-1:0] write_data,
  output logic [63:0]         read_ready,
  output logic [DATA_WID-1:0] read_data,
  output logic [63:0]         write_ready,
  output logic                error,
  output logic [31:0]         read_count,
  output logic [31:0]         write_count
);

  // Out-of-range LATENCY values are pinned to the nearest legal bound.
  localparam int unsigned LAT_CLAMP = (LATENCY < LAT_MIN) ? LAT_MIN :
                                      (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LAT_CLAMP - 1);
  localparam bit LAT_ONE = (LAT_CLAMP == 1);

  // Byte address legality against a window base.
  function automatic logic addr_ok(input logic [63:0] addr,
                                   input logic [63:0] base,
                                   input logic [63:0] size);
    logic [63:0] off;
    off = addr - base;
    return (addr >= base) && (addr[1:0] == 2'b00) &&
           (size == 64'(SIZE_BYTES)) && ((off >> (ADDR_WID + 2)) == 64'd0);
  endfunction

  // Word index inside the window; meaningful only for legal addresses.
  function automatic logic [ADDR_WID-1:0] addr_idx(input logic [63:0] addr,
                                                   input logic [63:0] base);
    return ADDR_WID'((addr - base) >> 2);
  endfunction

  logic [STATE_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_WID-1:0] cur_idx_q, cur_idx_d;
  logic                cur_ok_q, cur_ok_d;
  logic [DATA_WID-1:0] cur_wdata_q, cur_wdata_d;
  logic                pend_vld_q, pend_vld_d;
  logic                pend_wr_q, pend_wr_d;
  logic [ADDR_WID-1:0] pend_idx_q, pend_idx_d;
  logic                pend_ok_q, pend_ok_d;
  logic [DATA_WID-1:0] pend_wdata_q, pend_wdata_d;
  logic                err_q, err_d;
  logic                rd_rdy_q, rd_rdy_d;
  logic                wr_rdy_q, wr_rdy_d;
  logic [31:0]         rd_cnt_q, rd_cnt_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d;

  logic                wr_new_ok, rd_new_ok;
  logic [ADDR_WID-1:0] wr_new_idx, rd_new_idx;

  logic                svc_vld, svc_wr, svc_ok;
  logic [ADDR_WID-1:0] svc_idx;
  logic [DATA_WID-1:0] svc_wdata;
  logic                slot_free, take_wr, take_rd;

  logic                ram_en_c, ram_we_c, ram_zero_c;
  logic [ADDR_WID-1:0] ram_addr_c;
  logic [DATA_WID-1:0] ram_wdata_c;

  // Translate the incoming request addresses.
  always_comb begin
    wr_new_ok  = addr_ok(write_addr, write_base, write_size);
    wr_new_idx = addr_idx(write_addr, write_base);
    rd_new_ok  = addr_ok(read_addr, read_base, read_size);
    rd_new_idx = addr_idx(read_addr, read_base);
  end

  // Next-state logic: request selection, latency countdown, RAM control, pending slot.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_idx_d    = cur_idx_q;
    cur_ok_d     = cur_ok_q;
    cur_wdata_d  = cur_wdata_q;
    pend_vld_d   = pend_vld_q;
    pend_wr_d    = pend_wr_q;
    pend_idx_d   = pend_idx_q;
    pend_ok_d    = pend_ok_q;
    pend_wdata_d = pend_wdata_q;
    err_d        = err_q;
    rd_rdy_d     = 1'b0;
    wr_rdy_d     = 1'b0;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;

    ram_en_c     = 1'b0;
    ram_we_c     = 1'b0;
    ram_zero_c   = !cur_ok_q;
    ram_addr_c   = cur_idx_q;
    ram_wdata_c  = cur_wdata_q;

    svc_vld      = 1'b0;
    svc_wr       = 1'b0;
    svc_ok       = 1'b0;
    svc_idx      = '0;
    svc_wdata    = '0;
    slot_free    = !pend_vld_q;
    take_wr      = write_enable;
    take_rd      = read_enable;

    case (state_q)
      ST_IDLE: begin
        // Pending slot first, then write, then read.
        if (pend_vld_q) begin
          svc_vld    = 1'b1;
          svc_wr     = pend_wr_q;
          svc_ok     = pend_ok_q;
          svc_idx    = pend_idx_q;
          svc_wdata  = pend_wdata_q;
          pend_vld_d = 1'b0;
          slot_free  = 1'b1;
        end else if (write_enable) begin
          svc_vld    = 1'b1;
          svc_wr     = 1'b1;
          svc_ok     = wr_new_ok;
          svc_idx    = wr_new_idx;
          svc_wdata  = write_data;
          take_wr    = 1'b0;
        end else if (read_enable) begin
          svc_vld    = 1'b1;
          svc_ok     = rd_new_ok;
          svc_idx    = rd_new_idx;
          take_rd    = 1'b0;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_RD_RESP;
          rd_rdy_d   = 1'b1;
          ram_en_c   = 1'b1;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
        end
      end
      ST_WR_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_WR_RESP;
          wr_rdy_d   = 1'b1;
          ram_en_c   = cur_ok_q;
          ram_we_c   = 1'b1;
        end else begin
          cnt_d      = cnt_q - CNT_W'(1);
        end
      end
      ST_RD_RESP: begin
        state_d      = ST_IDLE;
        rd_cnt_d     = rd_cnt_q + 32'd1;
      end
      ST_WR_RESP: begin
        state_d      = ST_IDLE;
        wr_cnt_d     = wr_cnt_q + 32'd1;
      end
      default: begin
        state_d      = ST_IDLE;
      end
    endcase

    // Start the selected request; with unit latency the RAM access happens now.
    if (svc_vld) begin
      cur_idx_d   = svc_idx;
      cur_ok_d    = svc_ok;
      cur_wdata_d = svc_wdata;
      cnt_d       = LAT_LOAD;
      if (!svc_ok) begin
        err_d = 1'b1;
      end
      if (LAT_ONE) begin
        ram_addr_c  = svc_idx;
        ram_wdata_c = svc_wdata;
        ram_zero_c  = !svc_ok;
        if (svc_wr) begin
          state_d  = ST_WR_RESP;
          wr_rdy_d = 1'b1;
          ram_en_c = svc_ok;
          ram_we_c = 1'b1;
        end else begin
          state_d  = ST_RD_RESP;
          rd_rdy_d = 1'b1;
          ram_en_c = 1'b1;
        end
      end else begin
        state_d = svc_wr ? ST_WR_WAIT : ST_RD_WAIT;
      end
    end

    // Unserviced strobes park in the slot; a strobe that finds it full is lost.
    if (take_wr) begin
      if (slot_free) begin
        pend_vld_d   = 1'b1;
        pend_wr_d    = 1'b1;
        pend_ok_d    = wr_new_ok;
        pend_idx_d   = wr_new_idx;
        pend_wdata_d = write_data;
        slot_free    = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (take_rd) begin
      if (slot_free) begin
        pend_vld_d   = 1'b1;
        pend_wr_d    = 1'b0;
        pend_ok_d    = rd_new_ok;
        pend_idx_d   = rd_new_idx;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cur_idx_q    <= '0;
      cur_ok_q     <= 1'b0;
      cur_wdata_q  <= '0;
      pend_vld_q   <= 1'b0;
      pend_wr_q    <= 1'b0;
      pend_idx_q   <= '0;
      pend_ok_q    <= 1'b0;
      pend_wdata_q <= '0;
      err_q        <= 1'b0;
      rd_rdy_q     <= 1'b0;
      wr_rdy_q     <= 1'b0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_idx_q    <= cur_idx_d;
      cur_ok_q     <= cur_ok_d;
      cur_wdata_q  <= cur_wdata_d;
      pend_vld_q   <= pend_vld_d;
      pend_wr_q    <= pend_wr_d;
      pend_idx_q   <= pend_idx_d;
      pend_ok_q    <= pend_ok_d;
      pend_wdata_q <= pend_wdata_d;
      err_q        <= err_d;
      rd_rdy_q     <= rd_rdy_d;
      wr_rdy_q     <= wr_rdy_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
    end
  end

  mem_responder_ram #(
    .ADDR_WID (ADDR_WID),
    .DATA_WID (DATA_WID)
  ) u_ram (
    .clk       (clk),
    .rst_n     (reset),
    .en_i      (ram_en_c),
    .we_i      (ram_we_c),
    .rd_zero_i (ram_zero_c),
    .addr_i    (ram_addr_c),
    .wdata_i   (ram_wdata_c),
    .rdata_o   (read_data)
  );

  assign read_ready  = {63'd0, rd_rdy_q};
  assign write_ready = {63'd0, wr_rdy_q};
  assign error       = err_q;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the kernel bridge's host memory handshake. Accepts single-word read and write requests (enable pulse plus byte address), services them from an internal word-addressed RAM after a programmable latency, and answers with a one-cycle ready pulse. Used as the on-chip memory model and scratch store behind kernel wrappers, so a kernel can run with no external memory.

## Interface
- `ADDR_WID`, 14: word-index width; RAM depth is 2^ADDR_WID words.
- `DATA_WID`, 32: data word width.
- `LATENCY`, 2: cycles from the request-sampling edge to the ready pulse; legal range 1..15.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `read_base` in 64: byte base address of the read window.
- `write_base` in 64: byte base address of the write window.
- `read_enable` in 1: one-cycle read request strobe.
- `read_addr` in 64: byte address, captured with `read_enable`.
- `read_size` in 64: request size in bytes; only 4 is legal.
- `write_enable` in 1: one-cycle write request strobe.
- `write_addr` in 64: byte address, captured with `write_enable`.
- `write_size` in 64: request size in bytes; only 4 is legal.
- `write_data` in DATA_WID: write word, captured with `write_enable`.
- `read_ready` out 64: value 1 for exactly one cycle when `read_data` is valid, otherwise 0.
- `read_data` out DATA_WID: read word; holds its value until the next read completes.
- `write_ready` out 64: value 1 for exactly one cycle when the write is committed.
- `error` out 1: sticky protocol or address error flag.
- `read_count` out 32: completed reads, wrapping.
- `write_count` out 32: completed writes, wrapping.

## Operation
- States:
  - IDLE: waiting for a request.
  - RD_WAIT: read latency counting.
  - RD_RESP: `read_ready`=1 for one cycle.
  - WR_WAIT: write latency counting.
  - WR_RESP: `write_ready`=1 for one cycle.
- Address translation:
  - idx = (addr − base) >> 2.
  - Address is illegal if addr < base, addr[1:0] ≠ 0, size ≠ 4, or idx ≥ 2^ADDR_WID.
  - Illegal read: sets `error` and returns 0.
  - Illegal write: sets `error` and is dropped.
  - Both still complete with a ready pulse, so the initiator never deadlocks.
- IDLE, write request sampled: capture address and data, load counter with LATENCY−1, go to WR_WAIT (or straight to WR_RESP when LATENCY=1).
  - The RAM write occurs on the edge entering WR_RESP.
- IDLE, read request sampled: capture address, go to RD_WAIT.
  - The RAM read is issued so that data is registered into `read_data` on the edge entering RD_RESP.
- RD_RESP / WR_RESP: always return to IDLE on the next edge and increment the matching count.
- Simultaneous `read_enable` and `write_enable` in IDLE: the write is serviced first. The read is held in a one-deep pending slot and serviced from IDLE next.
- Enable while not in IDLE: captured into the pending slot.
  - If the slot is already full: set `error` and discard the new request.
- Pending slot has priority over new enables in IDLE.

## Timing
- Request sampled at edge E:
  - Ready is high during the cycle after edge E+LATENCY−1.
  - With the default LATENCY=2: request in cycle 0, ready in cycle 2.
- Back-to-back: the initiator may assert a new enable in the cycle directly after the ready pulse. It is sampled in IDLE with no bubble.
- Reset (asynchronous assert, any state including mid-request):
  - State returns to IDLE, pending slot is cleared, the in-flight request is lost.
  - `read_ready`=0, `write_ready`=0, `read_data`=0, `error`=0, counts=0.
  - RAM contents are not cleared.
- Counts wrap from 0xFFFFFFFF to 0 without setting `error`.

## Structure
- Shared package `mem_responder_pkg`: state enum, size constant 4, `LATENCY` bounds.
- One sub-module, `mem_responder_ram`: single-port synchronous RAM, DATA_WID × 2^ADDR_WID, one read-or-write per cycle, registered read.

## Test plan
- Write then read: write 0xDEADBEEF to base+0x10, then read the same address.
  - `write_ready` pulses in cycle 2.
  - `read_ready` pulses 2 cycles after the read enable with `read_data`=0xDEADBEEF.
  - Both counts equal 1.
- Back-to-back reads: re-assert `read_enable` in the cycle after each ready, 100 times.
  - No lost request; `read_count`=100.
  - Each ready is exactly one cycle wide.
- Simultaneous read and write to the same address:
  - The write completes first.
  - The read then returns the new data.
  - `error` stays 0.
- Illegal accesses: addr=base−4, then addr=base+2, then size=8.
  - Each completes with a ready pulse and read data 0.
  - `error`=1 and stays set.
  - RAM is unchanged.
- Overflow: issue three enables during one busy period.
  - Two are serviced.
  - The third sets `error`.
- Mid-request reset: assert `reset` low during RD_WAIT.
  - Outputs go to reset values immediately.
  - No ready pulse appears after release.
  - A previously written word is still readable.
